// File: rtl/io_stall_controller_pkg.sv
// io_stall_controller_pkg: FSM state encodings and CPU-wide I/O opcodes shared with the decoder
package io_stall_controller_pkg;
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    WAIT_IN  = 3'd1,
    WAIT_OUT = 3'd2,
    RESUME   = 3'd3,
    HALTED   = 3'd4
  } state_t;
  localparam logic [5:0] OP_IN  = 6'b011101;
  localparam logic [5:0] OP_OUT = 6'b100000;
  localparam logic [5:0] OP_HLT = 6'b011100;
endpackage

// File: rtl/io_stall_controller_button_debouncer.sv
// button_debouncer: synchronise and debounce a raw pushbutton, emit a one-cycle press pulse
//   clock, reset   : system clock, async active-high reset (level cleared to released)
//   button_raw     : asynchronous bouncing button input
//   press          : one-cycle pulse on each accepted 0->1 level change
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEBOUNCE_WIDTH  = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  output logic press
);
  localparam logic [DEBOUNCE_WIDTH-1:0] LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, level;
  logic [DEBOUNCE_WIDTH-1:0] cnt;
  // the accepted level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
  logic flip;
  assign flip = (sync2 != level) && (cnt == LAST);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
      cnt   <= (sync2 == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? sync2 : level;
      press <= flip && sync2;
    end
  end
endmodule

// File: rtl/io_stall_controller.sv
// io_stall_controller: stall the CPU via clock-enable around IN/OUT/HLT until a debounced confirm press
//   clock, reset : system clock, async active-high reset
//   opcode, instr_valid : instruction currently in decode
//   button_raw   : raw confirm pushbutton
//   cpu_enable   : CPU register/PC enable (0 freezes the core)
//   in_strobe    : one-cycle pulse to capture the switch bank
//   out_valid    : OUT value presented, awaiting acknowledge
//   halted       : core halted until reset
//   state        : current FSM state for debug LEDs
module io_stall_controller #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         DEBOUNCE_WIDTH  = 20,
  parameter logic [5:0] OP_IN  = io_stall_controller_pkg::OP_IN,
  parameter logic [5:0] OP_OUT = io_stall_controller_pkg::OP_OUT,
  parameter logic [5:0] OP_HLT = io_stall_controller_pkg::OP_HLT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       instr_valid,
  input  logic       button_raw,
  output logic       cpu_enable,
  output logic       in_strobe,
  output logic       out_valid,
  output logic       halted,
  output logic [2:0] state
);
  import io_stall_controller_pkg::*;
  state_t state_q, state_d;
  logic press, stall_op;
  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
  ) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .button_raw(button_raw),
    .press     (press)
  );
  assign stall_op = instr_valid && (opcode == OP_IN || opcode == OP_OUT || opcode == OP_HLT);
  // combinational stall so the I/O instruction never commits before its wait
  assign cpu_enable = !reset && ((state_q == RUN && !stall_op) || state_q == RESUME);
  assign out_valid  = state_q == WAIT_OUT;
  assign halted     = state_q == HALTED;
  assign state      = state_q;
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:      state_d = !stall_op ? RUN : opcode == OP_IN ? WAIT_IN : opcode == OP_OUT ? WAIT_OUT : HALTED;
      WAIT_IN:  state_d = press ? RESUME : WAIT_IN;
      WAIT_OUT: state_d = press ? RESUME : WAIT_OUT;
      RESUME:   state_d = RUN;
      HALTED:   state_d = HALTED;
      default:  state_d = RUN;
    endcase
  end
  // strobe coincides with RESUME so the switch capture and the IN commit share one edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      in_strobe <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_strobe <= state_q == WAIT_IN && press;
    end
  end
endmodule

// File: tb/tb_io_stall_controller.sv
// tb_io_stall_controller: directed self-checking bench with an in_strobe scoreboard
module tb_io_stall_controller;
  localparam logic [5:0] NOP = 6'b000001;
  localparam logic [5:0] IN  = 6'b011101;
  localparam logic [5:0] OUT = 6'b100000;
  localparam logic [5:0] HLT = 6'b011100;
  logic       clock = 1'b0, reset = 1'b1, instr_valid = 1'b0, button_raw = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       cpu_enable, in_strobe, out_valid, halted;
  logic [2:0] state;
  int checks = 0, failures = 0, cyc = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  io_stall_controller #(.DEBOUNCE_CYCLES(4), .DEBOUNCE_WIDTH(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .button_raw (button_raw),
    .cpu_enable (cpu_enable),
    .in_strobe  (in_strobe),
    .out_valid  (out_valid),
    .halted     (halted),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; every in_strobe pulse must match the next scoreboard entry
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (in_strobe !== 1'b0) begin
      int e;
      e = exp_q.size() != 0 ? exp_q.pop_front() : -1;
      chk("in_strobe_cycle", cyc, e);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk_se(input string tag, input logic [2:0] s, input logic en);
    chk({tag, "_state"}, state, s);
    chk({tag, "_en"}, cpu_enable, en);
  endtask

  initial begin
    #2;
    chk_se("reset", 3'd0, 1'b0);
    chk("reset_strobe", in_strobe, 0);
    chk("reset_ov", out_valid, 0);
    chk("reset_halted", halted, 0);
    // 1: asynchronous reset while waiting on OUT
    steps(2);
    reset = 1'b0; opcode = OUT; instr_valid = 1'b1;
    #1 chk_se("t1_decode", 3'd0, 1'b0);
    step();
    chk("t1_wait_state", state, 2);
    chk("t1_wait_ov", out_valid, 1);
    #2 reset = 1'b1;
    #1 chk_se("t1_async", 3'd0, 1'b0);
    chk("t1_async_ov", out_valid, 0);
    opcode = NOP;
    step();
    reset = 1'b0;
    #1 chk_se("t1_release", 3'd0, 1'b1);
    // 2: plain run
    for (int i = 0; i < 10; i++) begin
      step();
      chk_se("t2_run", 3'd0, 1'b1);
    end
    // 3: IN with held button
    opcode = IN; button_raw = 1'b1;
    exp_q.push_back(cyc + 7);
    #1 chk_se("t3_decode", 3'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_se("t3_wait", 3'd1, 1'b0);
    end
    step();
    chk_se("t3_resume", 3'd3, 1'b1);
    opcode = NOP;
    #1 chk("t3_resume_en_ignores_op", cpu_enable, 1);
    step();
    chk_se("t3_run", 3'd0, 1'b1);
    button_raw = 1'b0;
    steps(8);
    // 4: bounce in WAIT_OUT
    opcode = OUT;
    #1 chk("t4_decode_en", cpu_enable, 0);
    step();
    chk("t4_wait", state, 2);
    for (int i = 0; i < 10; i++) begin
      button_raw = (i < 4) ? ~i[0] : 1'b0;
      step();
      chk("t4_bounce_state", state, 2);
      chk("t4_bounce_ov", out_valid, 1);
    end
    button_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t4_press_wait", state, 2);
    end
    step();
    chk_se("t4_resume", 3'd3, 1'b1);
    chk("t4_resume_ov", out_valid, 0);
    opcode = NOP;
    step();
    chk_se("t4_run", 3'd0, 1'b1);
    button_raw = 1'b0;
    steps(8);
    // 5: halt, presses ignored, reset exits
    opcode = HLT;
    #1 chk("t5_decode_en", cpu_enable, 0);
    step();
    chk_se("t5_halt", 3'd4, 1'b0);
    chk("t5_halted", halted, 1);
    opcode = NOP;
    repeat (3) begin
      button_raw = 1'b1;
      steps(7);
      button_raw = 1'b0;
      steps(7);
      chk_se("t5_after_press", 3'd4, 1'b0);
      chk("t5_after_press_halted", halted, 1);
    end
    #2 reset = 1'b1;
    #1 chk("t5_reset_state", state, 0);
    chk("t5_reset_halted", halted, 0);
    step();
    reset = 1'b0;
    #1 chk_se("t5_release", 3'd0, 1'b1);
    // 6: press accepted the same cycle OUT enters decode is discarded
    button_raw = 1'b1;
    steps(5);
    chk_se("t6_pre", 3'd0, 1'b1);
    step();
    opcode = OUT;
    #1 chk_se("t6_coincide", 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_held_wait", state, 2);
    end
    button_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_release_wait", state, 2);
    end
    button_raw = 1'b1;
    steps(6);
    chk("t6_second_wait", state, 2);
    step();
    chk_se("t6_second_resume", 3'd3, 1'b1);
    opcode = NOP;
    step();
    chk_se("t6_run", 3'd0, 1'b1);
    // button still held into the next IN: no strobe until release and re-press
    opcode = IN;
    #1 chk("t6_in_decode_en", cpu_enable, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_se("t6_in_held", 3'd1, 1'b0);
    end
    button_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_in_released", state, 1);
    end
    button_raw = 1'b1;
    exp_q.push_back(cyc + 7);
    steps(6);
    chk("t6_in_repress_wait", state, 1);
    step();
    chk_se("t6_in_resume", 3'd3, 1'b1);
    opcode = NOP;
    step();
    chk_se("t6_in_run", 3'd0, 1'b1);
    button_raw = 1'b0;
    steps(8);
    chk("strobe_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
